vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Generates 640x480@60 Hz VGA raster timing from the 50 MHz system clock. Produces a pixel clock-enable, active-low sync pulses, blanking, and the drawX/drawY pixel coordinates consumed by the maze renderer and colour path. Also produces line/frame strobes for game-logic updates between frames. Sits directly upstream of the maze-map lookup.

Parameters:
CLK_DIV, 2, system clocks per pixel (>=1)
H_VISIBLE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)

Ports:
Clk  in  1  system clock, 50 MHz
Reset_n  in  1  asynchronous, active-low reset
pixel_ce  out  1  one-Clk pulse per pixel period
hs  out  1  horizontal sync, active low
vs  out  1  vertical sync, active low
blank_n  out  1  1 = visible pixel, 0 = blanking
drawX  out  10  current column, 0..H_TOTAL-1
drawY  out  10  current line, 0..V_TOTAL-1
line_start  out  1  one-Clk pulse when drawX returns to 0
frame_start  out  1  one-Clk pulse when (drawX,drawY) returns to (0,0)

Behaviour:
- One clock domain: Clk. Reset_n is asynchronous assert, active low; all flops clear on its falling edge.
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800). V_TOTAL likewise (525).
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. pixel_ce=1 exactly in cycles where div_cnt==CLK_DIV-1. If CLK_DIV=1, pixel_ce is constantly 1 after reset.
- Raster counters advance only on pixel_ce:
  - drawX increments, wrapping H_TOTAL-1 -> 0.
  - drawY increments only on the drawX wrap, wrapping V_TOTAL-1 -> 0.
  - New values are visible the Clk cycle after the pixel_ce cycle.
- hs, vs and blank_n are registered decodes of the next counter values, so they are cycle-aligned with drawX/drawY. There is zero relative skew between all raster outputs.
  - hs=0 iff drawX in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1] (656..751).
  - vs=0 iff drawY in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1] (490..491).
  - blank_n=1 iff drawX<H_VISIBLE and drawY<V_VISIBLE.
- line_start=1 for exactly the one Clk cycle in which drawX first reads 0 after a wrap.
- frame_start=1 for exactly the one Clk cycle in which (drawX,drawY) first reads (0,0) after a frame wrap. It coincides with that cycle's line_start.
- Reset values: div_cnt=0, drawX=0, drawY=0, hs=1, vs=1, blank_n=1, pixel_ce=0, line_start=0, frame_start=0. Strobes are not asserted on reset exit.
- Reset mid-frame: all outputs return to reset values immediately (asynchronously). Counting resumes from (0,0); the first pixel_ce comes CLK_DIV cycles after the Reset_n rising edge.
- Frame period = CLK_DIV*H_TOTAL*V_TOTAL Clk cycles (840000 at defaults).
- Counters never exceed TOTAL-1. Out-of-range states (e.g. upset) wrap to 0 on the next pixel_ce.

Optional Feature:
Macro VGA_FRAME_COUNT_EN.
- Defined: adds output port frame_count (16 bits, reset 0).
  - Increments by 1 in the cycle frame_start is asserted.
  - Wraps 0xFFFF -> 0.
  - Used to pace ghost/PacMan animation.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package vga_pkg:
  - default timing constants (H_VISIBLE..V_BP);
  - derived H_TOTAL, V_TOTAL;
  - coordinate typedef coord_t (logic [9:0]).
- Maze geometry constants (play-field left edge 96, right edge 544, tile size 16) also live in vga_pkg for the downstream map and sprite blocks.
- One sub-module: pixel_ce_div (parameter CLK_DIV; ports Clk, Reset_n, ce). It is the divider only.

Test Plan:
- Reset hold, then release -> drawX=0, drawY=0, hs=1, vs=1, blank_n=1, strobes 0. First pixel_ce 2 Clk after release, then every 2 Clk.
- Run one line -> hs low for exactly 96 pixel_ce periods starting when drawX=656. blank_n falls when drawX=640. line_start pulses once when drawX returns to 0, drawY=1.
- Run one frame -> vs low only while drawY in 490..491. blank_n=0 for all drawY>=480. frame_start pulses once, 840000 Clk after the previous one.
- Assert Reset_n low at drawX=300, drawY=200 for 3 cycles -> outputs return to reset values asynchronously. Recount from (0,0); no spurious line_start/frame_start.
- CLK_DIV=1 build -> pixel_ce stuck 1. drawX increments every Clk. Frame period 420000 Clk.
- VGA_FRAME_COUNT_EN build, preload/run 3 frames -> frame_count = 0,1,2,3 after successive frame_start pulses. Forced 0xFFFF wraps to 0.

Source files
------------

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared constants and types for the VGA raster and the blocks that consume
// its coordinates.
//   - Default 640x480@60 timing (visible, front porch, sync, back porch)
//     and the derived line and frame totals.
//   - coord_t: the raster coordinate type used for drawX and drawY.
//   - Maze play-field geometry, used by the map lookup and sprite blocks.
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;  // 800
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;  // 525

    typedef logic [9:0] coord_t;

    // Maze play-field geometry, in pixels.
    localparam int MAZE_LEFT  = 96;
    localparam int MAZE_RIGHT = 544;
    localparam int TILE_SIZE  = 16;

endpackage

// File: rtl/pixel_ce_div.sv
// ---------------------------------------------------------------------------
// pixel_ce_div
// Divides the system clock down to a one-cycle pixel clock-enable.
//   Clk     : system clock
//   Reset_n : asynchronous, active-low reset
//   ce      : one-Clk pulse every CLK_DIV cycles
// The pulse is registered. The first pulse appears CLK_DIV cycles after
// reset is released. With CLK_DIV=1 the pulse stays high from the first
// active edge on.
// ---------------------------------------------------------------------------
module pixel_ce_div #(
    parameter int CLK_DIV = 2
) (
    input  logic Clk,
    input  logic Reset_n,
    output logic ce
);

    localparam int              CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt;

    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_cnt <= '0;
            ce      <= 1'b0;
        end else begin
            ce      <= (div_cnt == LAST);
            div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Generates VGA raster timing (640x480@60 Hz by default, from a 50 MHz Clk).
//   Clk         : system clock
//   Reset_n     : asynchronous, active-low reset
//   pixel_ce    : one-Clk pulse per pixel period
//   hs, vs      : horizontal / vertical sync, active low
//   blank_n     : 1 = visible pixel
//   drawX/drawY : current column / line
//   line_start  : one-Clk pulse in the first cycle of a new line
//   frame_start : one-Clk pulse in the first cycle of a new frame
//   frame_count : frame counter, present only when VGA_FRAME_COUNT_EN is
//                 defined (it paces the sprite animation)
// All raster outputs come from the same clock edge, so there is no skew
// between them.
// ---------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::coord_t;
#(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FP      = vga_pkg::H_FP,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BP      = vga_pkg::H_BP,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FP      = vga_pkg::V_FP,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BP      = vga_pkg::V_BP
) (
    input  logic   Clk,
    input  logic   Reset_n,
    output logic   pixel_ce,
    output logic   hs,
    output logic   vs,
    output logic   blank_n,
    output coord_t drawX,
    output coord_t drawY,
    output logic   line_start,
    output logic   frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST    = coord_t'(H_TOT - 1);
    localparam coord_t V_LAST    = coord_t'(V_TOT - 1);
    localparam coord_t H_VIS     = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS     = coord_t'(V_VISIBLE);
    localparam coord_t HS_FIRST  = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t HS_LAST   = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam coord_t VS_FIRST  = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t VS_LAST   = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);

    pixel_ce_div #(.CLK_DIV(CLK_DIV)) u_div (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .ce      (pixel_ce)
    );

    logic   x_wrap;
    coord_t x_next;
    coord_t y_next;

    // The ">=" and ">" tests also send an out-of-range (upset) counter back
    // to 0 on the next pixel.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        x_wrap = (drawX >= H_LAST);
        x_next = x_wrap ? '0 : drawX + 10'd1;
        y_next = drawY;
        if (drawY > V_LAST) begin
            y_next = '0;
        end else if (x_wrap) begin
            y_next = (drawY == V_LAST) ? '0 : drawY + 10'd1;
        end
    end

    // The sync and blank flops decode the next counter values, so they
    // change on the same edge as drawX/drawY.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            drawX       <= '0;
            drawY       <= '0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            blank_n     <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pixel_ce) begin
            drawX       <= x_next;
            drawY       <= y_next;
            hs          <= !((x_next >= HS_FIRST) && (x_next <= HS_LAST));
            vs          <= !((y_next >= VS_FIRST) && (y_next <= VS_LAST));
            blank_n     <= (x_next < H_VIS) && (y_next < V_VIS);
            line_start  <= x_wrap;
            frame_start <= x_wrap && (y_next == '0);
        end else begin
            // The coordinates hold for CLK_DIV cycles. The strobes last one.
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    // Advances on the same edge that raises frame_start.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_count <= '0;
        end else if (pixel_ce && x_wrap && (y_next == '0)) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Bench for vga_timing_gen with three instances:
//   d0 : default timing, CLK_DIV=2
//   s2 : reduced raster (25x15), CLK_DIV=2, so whole frames fit the run
//   s1 : reduced raster (25x15), CLK_DIV=1
// Each instance is compared every cycle against a closed-form model. The
// model takes the number of active edges since reset release and returns
// what every output must be. A set of literal expectations pins the model.
// Define VGA_FRAME_COUNT_EN to also cover frame_count.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    typedef struct packed {
        logic        ce;
        logic        hs;
        logic        vs;
        logic        bn;
        logic        ls;
        logic        fs;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] fc;
    } obs_t;

    logic Clk;
    logic Reset_n;

    int checks = 0;
    int errors = 0;

    // ---------------- DUT instances ----------------
    logic       ce_d0, hs_d0, vs_d0, bn_d0, ls_d0, fs_d0;
    logic [9:0] x_d0, y_d0;
    logic [15:0] fc_d0;
    logic       ce_s2, hs_s2, vs_s2, bn_s2, ls_s2, fs_s2;
    logic [9:0] x_s2, y_s2;
    logic [15:0] fc_s2;
    logic       ce_s1, hs_s1, vs_s1, bn_s1, ls_s1, fs_s1;
    logic [9:0] x_s1, y_s1;
    logic [15:0] fc_s1;

    vga_timing_gen dut (
        .Clk(Clk), .Reset_n(Reset_n), .pixel_ce(ce_d0), .hs(hs_d0), .vs(vs_d0),
        .blank_n(bn_d0), .drawX(x_d0), .drawY(y_d0), .line_start(ls_d0),
        .frame_start(fs_d0)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_count(fc_d0)
`endif
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_VISIBLE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut_s2 (
        .Clk(Clk), .Reset_n(Reset_n), .pixel_ce(ce_s2), .hs(hs_s2), .vs(vs_s2),
        .blank_n(bn_s2), .drawX(x_s2), .drawY(y_s2), .line_start(ls_s2),
        .frame_start(fs_s2)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_count(fc_s2)
`endif
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_VISIBLE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut_s1 (
        .Clk(Clk), .Reset_n(Reset_n), .pixel_ce(ce_s1), .hs(hs_s1), .vs(vs_s1),
        .blank_n(bn_s1), .drawX(x_s1), .drawY(y_s1), .line_start(ls_s1),
        .frame_start(fs_s1)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_count(fc_s1)
`endif
    );

`ifndef VGA_FRAME_COUNT_EN
    assign fc_d0 = 16'd0;
    assign fc_s2 = 16'd0;
    assign fc_s1 = 16'd0;
`endif

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model. n = active Clk edges since reset release, d = CLK_DIV.
    // The first pixel_ce is visible after edge d and then after every d-th
    // edge. Each pixel_ce moves the raster one step on the following edge.
    function automatic obs_t model(input int n, input int d,
                                   input int hv, input int hf, input int hsw, input int hb,
                                   input int vv, input int vf, input int vsw, input int vb);
        obs_t o;
        int   ht, vt, a, x, y;
        bit   fresh;
        ht    = hv + hf + hsw + hb;
        vt    = vv + vf + vsw + vb;
        a     = (n == 0) ? 0 : (n - 1) / d;
        x     = a % ht;
        y     = (a / ht) % vt;
        fresh = (n >= 1) && ((n - 1) % d == 0) && (a > 0);
        o.ce  = (n >= 1) && (n % d == 0);
        o.hs  = !((x >= hv + hf) && (x < hv + hf + hsw));
        o.vs  = !((y >= vv + vf) && (y < vv + vf + vsw));
        o.bn  = (x < hv) && (y < vv);
        o.ls  = fresh && (x == 0);
        o.fs  = fresh && (x == 0) && (y == 0);
        o.x   = 10'(x);
        o.y   = 10'(y);
`ifdef VGA_FRAME_COUNT_EN
        o.fc  = 16'((a / (ht * vt)) % 65536);
`else
        o.fc  = 16'd0;
`endif
        return o;
    endfunction

    // ---------------- per-cycle compare and statistics ----------------
    bit armed = 0;
    int n     = 0;     // active edges since release
    int cyc   = 0;

    int hs_fall_x = -1, bn_fall_x = -1, hs_low_ce = 0;
    int ls0_cnt = 0, fs0_cnt = 0, ls0_first_y = -1;
    bit hs_prev = 1, bn_prev = 1;
    int fs2_cnt = 0, fs2_last = -1, fs2_period = -1;
    int fs1_last = -1, fs1_period = -1;
    int vs2_min = 1000, vs2_max = -1;
    int ce1_cnt = 0;

    initial begin
        obs_t a0, a2, a1;
        forever begin
            @(posedge Clk);
            if (Reset_n) n++;
            else         n = 0;
            cyc++;
            #5;
            if (armed) begin
                a0 = '{ce_d0, hs_d0, vs_d0, bn_d0, ls_d0, fs_d0, x_d0, y_d0, fc_d0};
                a2 = '{ce_s2, hs_s2, vs_s2, bn_s2, ls_s2, fs_s2, x_s2, y_s2, fc_s2};
                a1 = '{ce_s1, hs_s1, vs_s1, bn_s1, ls_s1, fs_s1, x_s1, y_s1, fc_s1};
                check("d0_raster", 64'(a0), 64'(model(n, 2, 640, 16, 96, 48, 480, 10, 2, 33)));
                check("s2_raster", 64'(a2), 64'(model(n, 2, 16, 2, 4, 3, 8, 2, 2, 3)));
                check("s1_raster", 64'(a1), 64'(model(n, 1, 16, 2, 4, 3, 8, 2, 2, 3)));

                if (hs_prev && !hs_d0 && hs_fall_x < 0) hs_fall_x = int'(x_d0);
                if (bn_prev && !bn_d0 && bn_fall_x < 0) bn_fall_x = int'(x_d0);
                hs_prev = hs_d0;
                bn_prev = bn_d0;
                if (!hs_d0 && ce_d0 && y_d0 == 10'd0) hs_low_ce++;
                if (ls_d0) begin
                    ls0_cnt++;
                    if (ls0_first_y < 0) ls0_first_y = int'(y_d0);
                end
                if (fs_d0) fs0_cnt++;

                if (fs_s2) begin
                    fs2_cnt++;
                    if (fs2_last >= 0) fs2_period = cyc - fs2_last;
                    fs2_last = cyc;
                end
                if (!vs_s2) begin
                    if (int'(y_s2) < vs2_min) vs2_min = int'(y_s2);
                    if (int'(y_s2) > vs2_max) vs2_max = int'(y_s2);
                end
                if (fs_s1) begin
                    if (fs1_last >= 0) fs1_period = cyc - fs1_last;
                    fs1_last = cyc;
                end
                if (Reset_n && ce_s1) ce1_cnt++;
            end
        end
    end

    // Reset-value pin for one instance, sampled between clock edges.
    task automatic check_reset_vals(input string name, input obs_t act);
        obs_t exp;
        exp = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 16'd0};
        check(name, 64'(act), 64'(exp));
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int waited;
        Reset_n = 1'b1;
        #3 Reset_n = 1'b0;
        #1;
        check_reset_vals("reset_d0", '{ce_d0, hs_d0, vs_d0, bn_d0, ls_d0, fs_d0, x_d0, y_d0, fc_d0});
        check_reset_vals("reset_s1", '{ce_s1, hs_s1, vs_s1, bn_s1, ls_s1, fs_s1, x_s1, y_s1, fc_s1});
        armed = 1;
        repeat (4) @(negedge Clk);
        Reset_n = 1'b1;

        // First pixel_ce two edges after release, and not on the first.
        @(posedge Clk); #6;
        check("ce_edge1", 64'(ce_d0), 64'(0));
        check("s1_ce_edge1", 64'(ce_s1), 64'(1));
        @(posedge Clk); #6;
        check("ce_edge2", 64'(ce_d0), 64'(1));
        check("x_edge2", 64'(x_d0), 64'(0));
        @(posedge Clk); #6;
        check("ce_edge3", 64'(ce_d0), 64'(0));
        check("x_edge3", 64'(x_d0), 64'(1));

        // 3303 edges in total: two d0 lines, several reduced frames.
        repeat (3300) @(posedge Clk);
        @(negedge Clk);
        check("hs_fall_x", 64'(hs_fall_x), 64'(656));
        check("hs_low_ce", 64'(hs_low_ce), 64'(96));
        check("blank_fall_x", 64'(bn_fall_x), 64'(640));
        check("ls_first_y", 64'(ls0_first_y), 64'(1));
        check("ls_count", 64'(ls0_cnt), 64'(2));
        check("fs_count_d0", 64'(fs0_cnt), 64'(0));
        check("fs2_count", 64'(fs2_cnt), 64'(4));
        check("fs2_period", 64'(fs2_period), 64'(750));
        check("fs1_period", 64'(fs1_period), 64'(375));
        check("vs2_low_min_y", 64'(vs2_min), 64'(10));
        check("vs2_low_max_y", 64'(vs2_max), 64'(11));
        check("s1_ce_count", 64'(ce1_cnt), 64'(3303));

        // Mid-frame reset once d0 reaches drawX=300.
        waited = 0;
        while (x_d0 != 10'd300 && waited < 2000) begin
            @(posedge Clk); #5;
            waited++;
        end
        check("reach_x300", 64'(x_d0), 64'(300));
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        check_reset_vals("midreset_d0", '{ce_d0, hs_d0, vs_d0, bn_d0, ls_d0, fs_d0, x_d0, y_d0, fc_d0});
        check_reset_vals("midreset_s2", '{ce_s2, hs_s2, vs_s2, bn_s2, ls_s2, fs_s2, x_s2, y_s2, fc_s2});
        repeat (3) @(negedge Clk);
        ls0_cnt = 0;
        fs0_cnt = 0;
        Reset_n = 1'b1;

        // One d0 line boundary, at edge 1601, and no frame strobe.
        repeat (2000) @(posedge Clk);
        @(negedge Clk);
        check("ls_after_reset", 64'(ls0_cnt), 64'(1));
        check("fs_after_reset", 64'(fs0_cnt), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
